// File: rtl/ex_mem_pipe_if.sv
// ex_mem_pipe_if: ID/EX-side inputs and EX/MEM-side outputs of the EX stage
//   master: drives stall/flush and the ID/EX fields, reads the EX/MEM register
//   slave : the EX stage itself (ex_mem_pipe)
interface ex_mem_pipe_if #(parameter int DATA_W = 64, parameter int PC_W = 32);
  logic              stall;
  logic              flush;
  logic              valid_in;
  logic              aluSrc_in;
  logic              memRead_in;
  logic              memWrite_in;
  logic              regWrite_in;
  logic              mem2reg_in;
  logic              branch_in;
  logic [1:0]        aluOp_in;
  logic [DATA_W-1:0] register_data_a_in;
  logic [DATA_W-1:0] register_data_b_in;
  logic [PC_W-1:0]   pc_in;
  logic [10:0]       aluControl_in;
  logic [4:0]        write_register_in;
  logic [DATA_W-1:0] signExtend_in;
  logic              valid_out;
  logic              memRead_out;
  logic              memWrite_out;
  logic              regWrite_out;
  logic              mem2reg_out;
  logic [DATA_W-1:0] alu_result_out;
  logic              zero_out;
  logic [DATA_W-1:0] store_data_out;
  logic [4:0]        write_register_out;
  logic [PC_W-1:0]   branch_target_out;
  logic              branch_taken_out;
  logic              illegal_op_out;
  modport master (
    output stall, flush, valid_in, aluSrc_in, memRead_in, memWrite_in, regWrite_in,
           mem2reg_in, branch_in, aluOp_in, register_data_a_in, register_data_b_in,
           pc_in, aluControl_in, write_register_in, signExtend_in,
    input  valid_out, memRead_out, memWrite_out, regWrite_out, mem2reg_out,
           alu_result_out, zero_out, store_data_out, write_register_out,
           branch_target_out, branch_taken_out, illegal_op_out
  );
  modport slave (
    input  stall, flush, valid_in, aluSrc_in, memRead_in, memWrite_in, regWrite_in,
           mem2reg_in, branch_in, aluOp_in, register_data_a_in, register_data_b_in,
           pc_in, aluControl_in, write_register_in, signExtend_in,
    output valid_out, memRead_out, memWrite_out, regWrite_out, mem2reg_out,
           alu_result_out, zero_out, store_data_out, write_register_out,
           branch_target_out, branch_taken_out, illegal_op_out
  );
endinterface

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: LEGv8 EX stage (ALU, CBZ zero test, branch target) plus EX/MEM register
//   CLK   : rising-edge clock
//   RESET : asynchronous active-high reset, clears every output
//   bus   : ex_mem_pipe_if.slave, ID/EX fields in, registered EX/MEM fields out
module ex_mem_pipe #(
  parameter int DATA_W = 64,
  parameter int PC_W   = 32
) (
  input logic          CLK,
  input logic          RESET,
  ex_mem_pipe_if.slave bus
);
  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  logic [DATA_W-1:0] w_a, w_b, w_alu;
  logic              w_rtype_ok, w_illegal, w_zero;
  logic [PC_W-1:0]   w_target;
  logic              r_valid, r_mem_read, r_mem_write, r_reg_write, r_mem2reg;
  logic [DATA_W-1:0] r_alu, r_store;
  logic              r_zero, r_taken, r_illegal;
  logic [4:0]        r_wr;
  logic [PC_W-1:0]   r_target;
  always_comb begin
    w_a        = bus.register_data_a_in;
    w_b        = bus.aluSrc_in ? bus.signExtend_in : bus.register_data_b_in;
    w_rtype_ok = bus.aluControl_in inside {OP_ADD, OP_SUB, OP_AND, OP_ORR};
    w_illegal  = (bus.aluOp_in == 2'b11) || (bus.aluOp_in == 2'b10 && !w_rtype_ok);
    w_alu      = bus.aluOp_in == 2'b00 ? w_a + w_b :
                 bus.aluOp_in == 2'b01 ? w_b :
                 w_illegal ? '0 :
                 bus.aluControl_in == OP_ADD ? w_a + w_b :
                 bus.aluControl_in == OP_SUB ? w_a - w_b :
                 bus.aluControl_in == OP_AND ? w_a & w_b : w_a | w_b;
    w_zero     = w_alu == '0;
    w_target   = bus.pc_in + {bus.signExtend_in[PC_W-3:0], 2'b00};
  end
  // a bubble (valid_in low) on a load clears the slot exactly like a flush
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET || bus.flush || (!bus.stall && !bus.valid_in)) begin
      r_valid     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem2reg   <= 1'b0;
      r_alu       <= '0;
      r_zero      <= 1'b0;
      r_store     <= '0;
      r_wr        <= '0;
      r_target    <= '0;
      r_taken     <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (bus.stall) begin
      r_taken     <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_valid     <= 1'b1;
      r_mem_read  <= bus.memRead_in && !w_illegal;
      r_mem_write <= bus.memWrite_in && !w_illegal;
      r_reg_write <= bus.regWrite_in && !w_illegal;
      r_mem2reg   <= bus.mem2reg_in;
      r_alu       <= w_alu;
      r_zero      <= w_zero;
      r_store     <= bus.register_data_b_in;
      r_wr        <= bus.write_register_in;
      r_target    <= w_target;
      r_taken     <= bus.branch_in && w_zero;
      r_illegal   <= w_illegal;
    end
  end
  assign bus.valid_out          = r_valid;
  assign bus.memRead_out        = r_mem_read;
  assign bus.memWrite_out       = r_mem_write;
  assign bus.regWrite_out       = r_reg_write;
  assign bus.mem2reg_out        = r_mem2reg;
  assign bus.alu_result_out     = r_alu;
  assign bus.zero_out           = r_zero;
  assign bus.store_data_out     = r_store;
  assign bus.write_register_out = r_wr;
  assign bus.branch_target_out  = r_target;
  assign bus.branch_taken_out   = r_taken;
  assign bus.illegal_op_out     = r_illegal;
endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: scoreboard bench for ex_mem_pipe
module tb_ex_mem_pipe;
  typedef struct packed {
    logic        valid, mr, mw, rw, m2r;
    logic [63:0] alu;
    logic        zero;
    logic [63:0] sd;
    logic [4:0]  wr;
    logic [31:0] tgt;
    logic        bt, ill;
  } exp_t;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t cur = '0;
  ex_mem_pipe_if #(.DATA_W(64), .PC_W(32)) bus ();
  ex_mem_pipe #(.DATA_W(64), .PC_W(32)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic v, input logic [1:0] op, input logic [10:0] ctl,
                                 input logic [63:0] a, input logic [63:0] b_reg, input logic [63:0] imm,
                                 input logic src, input logic mr, input logic mw, input logic rw,
                                 input logic m2r, input logic br, input logic [31:0] pc,
                                 input logic [4:0] wr);
    exp_t e = '0;
    logic [63:0] b = src ? imm : b_reg;
    logic ill = 1'b0;
    logic [63:0] r = 64'd0;
    logic [63:0] scaled = imm * 64'd4;
    case (op)
      2'd0: r = a + b;
      2'd1: r = b;
      2'd2: case (ctl)
              11'h458: r = a + b;
              11'h658: r = a - b;
              11'h450: r = a & b;
              11'h550: r = a | b;
              default: ill = 1'b1;
            endcase
      default: ill = 1'b1;
    endcase
    if (!v) return e;
    e.valid = 1'b1;
    e.mr    = mr & ~ill;
    e.mw    = mw & ~ill;
    e.rw    = rw & ~ill;
    e.m2r   = m2r;
    e.alu   = r;
    e.zero  = (r == 64'd0);
    e.sd    = b_reg;
    e.wr    = wr;
    e.tgt   = pc + scaled[31:0];
    e.bt    = br & (r == 64'd0);
    e.ill   = ill;
    return e;
  endfunction
  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, ".valid"}, 64'(bus.valid_out), 64'(e.valid));
    check({tag, ".memRead"}, 64'(bus.memRead_out), 64'(e.mr));
    check({tag, ".memWrite"}, 64'(bus.memWrite_out), 64'(e.mw));
    check({tag, ".regWrite"}, 64'(bus.regWrite_out), 64'(e.rw));
    check({tag, ".mem2reg"}, 64'(bus.mem2reg_out), 64'(e.m2r));
    check({tag, ".alu"}, bus.alu_result_out, e.alu);
    check({tag, ".zero"}, 64'(bus.zero_out), 64'(e.zero));
    check({tag, ".store"}, bus.store_data_out, e.sd);
    check({tag, ".wr"}, 64'(bus.write_register_out), 64'(e.wr));
    check({tag, ".target"}, 64'(bus.branch_target_out), 64'(e.tgt));
    check({tag, ".taken"}, 64'(bus.branch_taken_out), 64'(e.bt));
    check({tag, ".illegal"}, 64'(bus.illegal_op_out), 64'(e.ill));
  endtask
  task automatic step(input string tag);
    @(posedge CLK);
    #1;
    compare(tag);
  endtask
  task automatic issue(input string tag, input logic v, input logic [1:0] op, input logic [10:0] ctl,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                       input logic src, input logic mr, input logic mw, input logic rw,
                       input logic m2r, input logic br, input logic [31:0] pc, input logic [4:0] wr);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.valid_in = v;
    bus.aluOp_in = op;
    bus.aluControl_in = ctl;
    bus.register_data_a_in = a;
    bus.register_data_b_in = b;
    bus.signExtend_in = imm;
    bus.aluSrc_in = src;
    bus.memRead_in = mr;
    bus.memWrite_in = mw;
    bus.regWrite_in = rw;
    bus.mem2reg_in = m2r;
    bus.branch_in = br;
    bus.pc_in = pc;
    bus.write_register_in = wr;
    cur = model(v, op, ctl, a, b, imm, src, mr, mw, rw, m2r, br, pc, wr);
    sb.push_back(cur);
    step(tag);
  endtask
  task automatic scramble();
    bus.valid_in = 1'b1;
    bus.aluOp_in = 2'($urandom_range(0, 3));
    bus.aluControl_in = 11'($urandom);
    bus.register_data_a_in = {$urandom, $urandom};
    bus.register_data_b_in = {$urandom, $urandom};
    bus.signExtend_in = {$urandom, $urandom};
    bus.pc_in = $urandom;
    bus.write_register_in = 5'($urandom);
    bus.regWrite_in = 1'b1;
    bus.memRead_in = 1'b1;
    bus.branch_in = 1'b1;
  endtask
  task automatic hold(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      scramble();
      bus.stall = 1'b1;
      bus.flush = 1'b0;
      cur.bt = 1'b0;
      cur.ill = 1'b0;
      sb.push_back(cur);
      step(tag);
    end
  endtask
  localparam logic [10:0] ADD = 11'b10001011000;
  localparam logic [10:0] SUB = 11'b11001011000;
  localparam logic [10:0] AND = 11'b10001010000;
  localparam logic [10:0] ORR = 11'b10101010000;
  initial begin
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    scramble();
    #12;
    cur = '0;
    sb.push_back(cur);
    compare("reset_state");
    #10 RESET = 1'b0;
    issue("add_imm", 1, 2'b00, 11'd0, 64'd5, 64'd7, 64'd0, 0, 0, 0, 1, 0, 0, 32'h10, 5'd3);
    issue("r_add_wrap", 1, 2'b10, ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0, 0, 0, 1, 0, 0, 32'h14, 5'd4);
    check("r_add_wrap.zero_direct", 64'(bus.zero_out), 64'd1);
    issue("r_sub", 1, 2'b10, SUB, 64'd10, 64'd3, 64'd0, 0, 0, 0, 1, 0, 0, 32'h18, 5'd5);
    check("r_sub.direct", bus.alu_result_out, 64'd7);
    issue("r_and", 1, 2'b10, AND, 64'hF0, 64'h3C, 64'd0, 0, 0, 0, 1, 0, 0, 32'h1C, 5'd6);
    check("r_and.direct", bus.alu_result_out, 64'h30);
    issue("r_orr", 1, 2'b10, ORR, 64'hF0, 64'h0F, 64'd0, 0, 0, 0, 1, 0, 0, 32'h20, 5'd7);
    check("r_orr.direct", bus.alu_result_out, 64'hFF);
    issue("ldur", 1, 2'b00, 11'd0, 64'h100, 64'h55AA, 64'd8, 1, 1, 0, 1, 1, 0, 32'h24, 5'd8);
    check("ldur.direct", bus.alu_result_out, 64'h108);
    issue("cbz_taken", 1, 2'b01, 11'd0, 64'd9, 64'd0, 64'd3, 0, 0, 0, 0, 0, 1, 32'h40, 5'd0);
    check("cbz_taken.target_direct", 64'(bus.branch_target_out), 64'h4C);
    hold("cbz_pulse_once", 1);
    issue("cbz_not_taken", 1, 2'b01, 11'd0, 64'd9, 64'd5, 64'd3, 0, 0, 0, 0, 0, 1, 32'h40, 5'd0);
    issue("cbz_neg_imm", 1, 2'b01, 11'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 0, 1, 32'h4, 5'd0);
    issue("stur", 1, 2'b00, 11'd0, 64'h200, 64'hDEAD_BEEF, 64'h10, 1, 0, 1, 0, 0, 0, 32'h50, 5'd9);
    hold("stur_stall", 3);
    scramble();
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    cur = '0;
    sb.push_back(cur);
    step("flush_and_stall");
    issue("illegal_rtype", 1, 2'b10, 11'h7FF, 64'd1, 64'd2, 64'd0, 0, 1, 1, 1, 0, 0, 32'h60, 5'd10);
    issue("bubble", 0, 2'b00, 11'd0, 64'd1, 64'd2, 64'd0, 0, 1, 0, 1, 0, 1, 32'h64, 5'd11);
    issue("illegal_op11", 1, 2'b11, ADD, 64'd1, 64'd2, 64'd0, 0, 0, 0, 1, 0, 0, 32'h68, 5'd12);
    hold("illegal_pulse_once", 1);
    for (int i = 0; i < 6; i++) begin
      logic [63:0] a = {$urandom, $urandom};
      logic [63:0] b = {$urandom, $urandom};
      logic [10:0] c;
      case (i % 4)
        0: c = ADD;
        1: c = SUB;
        2: c = AND;
        default: c = ORR;
      endcase
      issue("rand_rtype", 1, 2'b10, c, a, b, {$urandom, $urandom}, 0, 0, 0, 1, 0, 0, $urandom, 5'(i));
    end
    issue("pre_reset_add", 1, 2'b00, 11'd0, 64'd5, 64'd7, 64'd0, 0, 0, 0, 1, 0, 1, 32'h70, 5'd13);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    cur = '0;
    sb.push_back(cur);
    compare("reset_async");
    scramble();
    bus.stall = 1'b0;
    sb.push_back(cur);
    step("reset_held");
    @(negedge CLK);
    RESET = 1'b0;
    issue("post_reset_cbz", 1, 2'b01, 11'd0, 64'd0, 64'd0, 64'd1, 0, 0, 0, 0, 0, 1, 32'h80, 5'd1);
    issue("post_reset_bubble", 0, 2'b00, 11'd0, 64'd0, 64'd0, 64'd0, 0, 0, 0, 0, 0, 0, 32'h0, 5'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
